polyline_drawer: RTL

Parametrised successor to line_drawer. Accepts a stream of vertices over a valid/ready handshake and rasterises each consecutive pair as a Bresenham segment, one pixel per clock, into a framebuffer write port. Pixels carry a multi-bit colour. Sits between the plot-point generator and the framebuffer RAM write port.

---
 rtl/polyline_drawer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/polyline_drawer.sv
// Polyline rasteriser: accepts vertices over valid/ready and draws each consecutive
// pair as a Bresenham segment, one pixel per clock, into a framebuffer write port.
module polyline_drawer #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int COLOR_WIDTH       = 1,
    parameter int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
    parameter int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS),
    parameter int ADDR_WIDTH        = $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   point_valid,
    output logic                   point_ready,
    input  logic [X_WIDTH-1:0]     point_x,
    input  logic [Y_WIDTH-1:0]     point_y,
    input  logic [COLOR_WIDTH-1:0] point_color,
    input  logic                   point_last,
    output logic                   busy,
    output logic                   write_enable,
    output logic [ADDR_WIDTH-1:0]  write_addr,
    output logic [COLOR_WIDTH-1:0] write_data
);

    localparam int MW = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
    localparam int PW = MW + 1;
    localparam int EW = MW + 2;

    typedef enum logic [1:0] {EMPTY, HELD, DRAW} state_t;

    typedef struct packed {
        logic [X_WIDTH-1:0] x;
        logic [Y_WIDTH-1:0] y;
        logic [EW-1:0]      e;
    } pos_t;

    // One Bresenham step; the error term is carried as raw bits and treated as signed here.
    function automatic pos_t bstep(input pos_t p, input logic signed [EW-1:0] ddx,
                                   input logic signed [EW-1:0] ddy, input logic xneg,
                                   input logic yneg);
        pos_t               q;
        logic signed [EW:0] e2, dxw, dyw;
        q   = p;
        e2  = {p.e, 1'b0};
        dxw = ddx;
        dyw = ddy;
        if (e2 >= dyw) begin
            q.e = q.e + ddy;
            q.x = xneg ? p.x - X_WIDTH'(1) : p.x + X_WIDTH'(1);
        end
        if (e2 <= dxw) begin
            q.e = q.e + ddx;
            q.y = yneg ? p.y - Y_WIDTH'(1) : p.y + Y_WIDTH'(1);
        end
        return q;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [X_WIDTH-1:0] x,
                                                      input logic [Y_WIDTH-1:0] y);
        return ADDR_WIDTH'(y) * ADDR_WIDTH'(HOR_ACTIVE_PIXELS) + ADDR_WIDTH'(x);
    endfunction

    state_t                state, state_nx;
    logic                  alive, first_r, last_r, accept;
    logic [X_WIDTH-1:0]    hx, nx, adx;
    logic [Y_WIDTH-1:0]    hy, ny, ady;
    logic signed [EW-1:0]  dx_r, dy_r, s_dx, s_dy;
    logic                  sxn_r, syn_r, s_sxn, s_syn;
    logic [PW-1:0]         seg_len, pend;
    pos_t                  cur, cur_nx, seg_start, seg_skip;

    assign point_ready = alive && (state != DRAW);
    assign busy        = (state != EMPTY);
    assign accept      = point_valid && point_ready;

    // Segment setup from the held vertex to the (saturated) incoming vertex.
    always_comb begin
        nx = (32'(point_x) > 32'(HOR_ACTIVE_PIXELS - 1)) ? X_WIDTH'(HOR_ACTIVE_PIXELS - 1) : point_x;
        ny = (32'(point_y) > 32'(VER_ACTIVE_PIXELS - 1)) ? Y_WIDTH'(VER_ACTIVE_PIXELS - 1) : point_y;
        s_sxn   = nx < hx;
        s_syn   = ny < hy;
        adx     = s_sxn ? hx - nx : nx - hx;
        ady     = s_syn ? hy - ny : ny - hy;
        s_dx    = $signed(EW'(adx));
        s_dy    = -$signed(EW'(ady));
        seg_len = (PW'(adx) >= PW'(ady)) ? PW'(adx) : PW'(ady);
        seg_start.x = hx;
        seg_start.y = hy;
        seg_start.e = s_dx + s_dy;
        seg_skip = bstep(seg_start, s_dx, s_dy, s_sxn, s_syn);
        cur_nx   = bstep(cur, dx_r, dy_r, sxn_r, syn_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    // DRAW stays one cycle past the last pixel so ready is low for k+1 cycles.
    always_comb begin
        state_nx = state;
        case (state)
            EMPTY:   if (accept) state_nx = point_last ? DRAW : HELD;
            HELD:    if (accept) state_nx = DRAW;
            DRAW:    if (pend == '0 && !write_enable) state_nx = last_r ? EMPTY : HELD;
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive        <= 1'b0;
            first_r      <= 1'b0;
            last_r       <= 1'b0;
            hx           <= '0;
            hy           <= '0;
            dx_r         <= '0;
            dy_r         <= '0;
            sxn_r        <= 1'b0;
            syn_r        <= 1'b0;
            pend         <= '0;
            cur          <= '0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            alive        <= 1'b1;
            write_enable <= 1'b0;
            case (state)
                EMPTY: if (accept) begin
                    if (point_last) begin
                        write_enable <= 1'b1;
                        write_addr   <= addr_of(nx, ny);
                        write_data   <= point_color;
                        pend         <= '0;
                        last_r       <= 1'b1;
                    end else begin
                        hx      <= nx;
                        hy      <= ny;
                        first_r <= 1'b1;
                    end
                end
                HELD: if (accept) begin
                    hx      <= nx;
                    hy      <= ny;
                    first_r <= 1'b0;
                    last_r  <= point_last;
                    dx_r    <= s_dx;
                    dy_r    <= s_dy;
                    sxn_r   <= s_sxn;
                    syn_r   <= s_syn;
                    if (first_r) begin
                        cur          <= seg_start;
                        write_enable <= 1'b1;
                        write_addr   <= addr_of(hx, hy);
                        write_data   <= point_color;
                        pend         <= seg_len;
                    end else if (seg_len != '0) begin
                        // Start pixel already written by the previous segment.
                        cur          <= seg_skip;
                        write_enable <= 1'b1;
                        write_addr   <= addr_of(seg_skip.x, seg_skip.y);
                        write_data   <= point_color;
                        pend         <= seg_len - PW'(1);
                    end else begin
                        pend <= '0;
                    end
                end
                DRAW: if (pend != '0) begin
                    cur          <= cur_nx;
                    write_enable <= 1'b1;
                    write_addr   <= addr_of(cur_nx.x, cur_nx.y);
                    pend         <= pend - PW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
